// File: rtl/bit_scan_serializer.sv
// Serialises the set bits of an accepted word into one index/one-hot beat per cycle, LSB- or MSB-first.
// Optional: define BIT_SCAN_ZERO_BEAT_EN to emit a single empty beat for an all-zero word.
module bit_scan_serializer #(
    parameter  int DATA_W = 16,
    localparam int IDX_W  = $clog2(DATA_W),
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              dir_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [DATA_W-1:0] onehot_o,
    output logic              first_o,
    output logic              last_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              idx_val_o,
    input  logic              idx_rdy_i
);

    typedef enum logic [0:0] {IDLE, SCAN} state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  rem_q;
    logic               dir_q;
    logic [DATA_W-1:0]  oh_q;
    logic [IDX_W-1:0]   idx_q;
    logic               first_q;
    logic               last_q;
    logic [CNT_W-1:0]   count_q;

    logic [DATA_W-1:0]  rem_next;
    logic [DATA_W-1:0]  accept_oh;
    logic [DATA_W-1:0]  next_oh;

    // NOTE: every function result starts from a default so no path leaves it unassigned.
    function automatic logic [DATA_W-1:0] isolate(input logic [DATA_W-1:0] v, input logic msb_first);
        logic [DATA_W-1:0] r;
        r = '0;
        if (!msb_first) begin
            r = v & (~v + DATA_W'(1));
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (v[i]) begin
                    r    = '0;
                    r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [DATA_W-1:0] oh);
        logic [IDX_W-1:0] e;
        e = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (oh[i]) e = IDX_W'(i);
        end
        return e;
    endfunction

    function automatic logic single_bit(input logic [DATA_W-1:0] v);
        return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) c = c + CNT_W'(1);
        end
        return c;
    endfunction

    // Outputs are pre-computed one beat ahead so every output comes straight from a flop.
    assign rem_next  = rem_q & ~oh_q;
    assign accept_oh = isolate(data_i, dir_i);
    assign next_oh   = isolate(rem_next, dir_q);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            oh_q    <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_val_i) begin
                        rem_q   <= data_i;
                        dir_q   <= dir_i;
                        count_q <= popcount(data_i);
                        oh_q    <= accept_oh;
                        idx_q   <= encode(accept_oh);
`ifdef BIT_SCAN_ZERO_BEAT_EN
                        state_q <= SCAN;
                        first_q <= 1'b1;
                        last_q  <= single_bit(data_i) || (data_i == '0);
`else
                        last_q  <= single_bit(data_i);
                        if (data_i != '0) begin
                            state_q <= SCAN;
                            first_q <= 1'b1;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (idx_rdy_i) begin
                        rem_q   <= rem_next;
                        oh_q    <= next_oh;
                        idx_q   <= encode(next_oh);
                        last_q  <= single_bit(rem_next);
                        first_q <= 1'b0;
                        if (last_q) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_rdy_o = rst_n_i && (state_q == IDLE);
    assign idx_val_o  = (state_q == SCAN);
    assign idx_o      = idx_q;
    assign onehot_o   = oh_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Randomised self-checking bench for bit_scan_serializer; expected beats come from a list model of the word.
module tb_bit_scan_serializer;

    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [DATA_W-1:0] data_i;
    logic              dir_i;
    logic              data_val_i;
    logic              data_rdy_o;
    logic [IDX_W-1:0]  idx_o;
    logic [DATA_W-1:0] onehot_o;
    logic              first_o;
    logic              last_o;
    logic [CNT_W-1:0]  count_o;
    logic              idx_val_o;
    logic              idx_rdy_i;

    int checks = 0;
    int errors = 0;

    bit_scan_serializer #(.DATA_W(DATA_W)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .data_i     (data_i),
        .dir_i      (dir_i),
        .data_val_i (data_val_i),
        .data_rdy_o (data_rdy_o),
        .idx_o      (idx_o),
        .onehot_o   (onehot_o),
        .first_o    (first_o),
        .last_o     (last_o),
        .count_o    (count_o),
        .idx_val_o  (idx_val_o),
        .idx_rdy_i  (idx_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_beat(input int idx, input logic [DATA_W-1:0] oh, input bit f, input bit l,
                              input int cnt);
        check("idx_val", 32'(idx_val_o), 32'd1);
        check("data_rdy_scan", 32'(data_rdy_o), 32'd0);
        check("idx", 32'(idx_o), 32'(idx));
        check("onehot", 32'(onehot_o), 32'(oh));
        check("first", 32'(first_o), 32'(f));
        check("last", 32'(last_o), 32'(l));
        check("count", 32'(count_o), 32'(cnt));
    endtask

    // Called at a falling edge with the block idle; returns at a falling edge with the block idle again.
    task automatic run_word(input logic [DATA_W-1:0] d, input logic dr, input int max_stall,
                            input bit toggle_dir);
        int exp_idx[$];
        int cnt;
        int n;
        int stall;
        logic [DATA_W-1:0] oh;
        exp_idx = {};
        cnt = $countones(d);
        for (int k = 0; k < DATA_W; k++) begin
            int bitpos;
            bitpos = dr ? (DATA_W - 1 - k) : k;
            if (d[bitpos]) exp_idx.push_back(bitpos);
        end
        check("rdy_before_word", 32'(data_rdy_o), 32'd1);
        data_i     = d;
        dir_i      = dr;
        data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        data_i     = DATA_W'($urandom);
        if (toggle_dir) dir_i = ~dr;
        n = exp_idx.size();
        if (n == 0) begin
`ifdef BIT_SCAN_ZERO_BEAT_EN
            idx_rdy_i = 1'b1;
            check_beat(0, '0, 1'b1, 1'b1, 0);
            @(negedge clk_i);
`endif
        end else begin
            for (int b = 0; b < n; b++) begin
                oh = DATA_W'(1) << exp_idx[b];
                stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
                idx_rdy_i = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    check_beat(exp_idx[b], oh, b == 0, b == n - 1, cnt);
                    @(negedge clk_i);
                end
                idx_rdy_i = 1'b1;
                check_beat(exp_idx[b], oh, b == 0, b == n - 1, cnt);
                @(negedge clk_i);
            end
        end
        check("idx_val_after_word", 32'(idx_val_o), 32'd0);
        check("rdy_after_word", 32'(data_rdy_o), 32'd1);
    endtask

    initial begin
        rst_n_i    = 1'b0;
        data_i     = '0;
        dir_i      = 1'b0;
        data_val_i = 1'b0;
        idx_rdy_i  = 1'b0;
        #3;
        check("rst_rdy", 32'(data_rdy_o), 32'd0);
        check("rst_val", 32'(idx_val_o), 32'd0);
        check("rst_idx", 32'(idx_o), 32'd0);
        check("rst_onehot", 32'(onehot_o), 32'd0);
        check("rst_first", 32'(first_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        #19 rst_n_i = 1'b1;
        @(negedge clk_i);

        run_word(8'hA5, 1'b0, 0, 1'b0);
        run_word(8'hA5, 1'b1, 0, 1'b1);

        // First beat of 0x24 held off for three cycles.
        check("rdy_before_stall", 32'(data_rdy_o), 32'd1);
        data_i = 8'h24; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        idx_rdy_i  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_beat(2, 8'h04, 1'b1, 1'b0, 2);
            @(negedge clk_i);
        end
        idx_rdy_i = 1'b1;
        check_beat(2, 8'h04, 1'b1, 1'b0, 2);
        @(negedge clk_i);
        check_beat(5, 8'h20, 1'b0, 1'b1, 2);
        @(negedge clk_i);
        check("rdy_after_stall", 32'(data_rdy_o), 32'd1);

        run_word(8'h80, 1'b0, 0, 1'b0);
        run_word(8'hFF, 1'b1, 0, 1'b0);
        run_word(8'h00, 1'b0, 0, 1'b0);
        run_word(8'h01, 1'b1, 1, 1'b0);

        for (int w = 0; w < 40; w++) begin
            logic [DATA_W-1:0] d;
            d = (w % 10 == 9) ? '0 : DATA_W'($urandom);
            run_word(d, 1'($urandom), 2, 1'($urandom));
        end

        // Asynchronous reset in the middle of 0xF0.
        data_i = 8'hF0; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        idx_rdy_i  = 1'b1;
        check_beat(4, 8'h10, 1'b1, 1'b0, 4);
        @(negedge clk_i);
        check_beat(5, 8'h20, 1'b0, 1'b0, 4);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(data_rdy_o), 32'd0);
        check("mid_rst_val", 32'(idx_val_o), 32'd0);
        check("mid_rst_idx", 32'(idx_o), 32'd0);
        check("mid_rst_onehot", 32'(onehot_o), 32'd0);
        check("mid_rst_first", 32'(first_o), 32'd0);
        check("mid_rst_last", 32'(last_o), 32'd0);
        check("mid_rst_count", 32'(count_o), 32'd0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("post_rst_val", 32'(idx_val_o), 32'd0);
            check("post_rst_rdy", 32'(data_rdy_o), 32'd1);
        end
        run_word(8'h03, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bit_scan_serializer.md
# bit_scan_serializer

Accepts a DATA_W-bit word over a valid/ready handshake and emits, one beat per cycle, the index and one-hot mask of every set bit, scanning from the LSB or the MSB as selected per word. This is the sequential successor of the combinational left/right priority encoder. Repeated isolate-and-clear of the highest-priority bit turns a request vector into a stream of grants or indices. It sits between request-collection logic and any consumer that services one request at a time, such as an arbiter back end or an interrupt dispatcher.

## Interface
Parameters (derived widths are localparams, not overridable):
- DATA_W, 16, input word width; must be >= 2
- IDX_W, $clog2(DATA_W), width of idx_o (derived)
- CNT_W, $clog2(DATA_W+1), width of count_o (derived)

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- data_i  in  DATA_W  input word
- dir_i  in  1  scan direction: 0 = LSB-first, 1 = MSB-first; sampled with data_i
- data_val_i  in  1  input word valid
- data_rdy_o  out  1  block can accept a word
- idx_o  out  IDX_W  index of the current bit
- onehot_o  out  DATA_W  one-hot mask of the current bit
- first_o  out  1  current beat is the first of the word
- last_o  out  1  current beat is the last of the word
- count_o  out  CNT_W  popcount of the accepted word, held for all beats of that word
- idx_val_o  out  1  output beat valid
- idx_rdy_i  in  1  downstream accepts the beat

## Operation
- FSM states: IDLE, SCAN. rst_n_i low forces IDLE immediately and clears all state registers.
- IDLE: data_rdy_o=1, idx_val_o=0.
- Accept: a word is accepted when data_val_i && data_rdy_o.
  - The block captures rem <= data_i, dir <= dir_i, count <= popcount(data_i) and first <= 1.
  - If data_i != 0, the next state is SCAN.
- SCAN: data_rdy_o=0, idx_val_o=1.
  - onehot_o is the lowest set bit of rem when dir=0 (rem & (~rem+1)), or the highest set bit when dir=1.
  - idx_o is the binary encoding of onehot_o.
  - last_o = (rem has exactly one bit set). first_o = first register.
- Beat handshake: a beat completes when idx_val_o && idx_rdy_i. On completion:
  - rem <= rem & ~onehot_o and first <= 0.
  - If last_o, the next state is IDLE.
- Stability: while idx_val_o && !idx_rdy_i, all outputs hold stable.
- No overlap: a new word is never accepted during SCAN. data_rdy_o does not depend combinationally on idx_rdy_i.
- Zero word: behaviour is given under Configuration.

## Timing
- Reset values: data_rdy_o=0 while rst_n_i is low and 1 after release. idx_val_o=0, idx_o=0, onehot_o=0, first_o=0, last_o=0, count_o=0.
- Latency: a word accepted at edge N presents its first beat in the cycle after N.
- Throughput: popcount(data) beats plus 1 IDLE cycle per word, with idx_rdy_i held high.
- Reset mid-SCAN: outputs return to their reset values asynchronously. The remaining beats are discarded and no beat is emitted after release until a new word is accepted.
- DATA_W not a power of two: idx_o never exceeds DATA_W-1.

## Configuration
- Macro: BIT_SCAN_ZERO_BEAT_EN.
- Defined: an accepted zero word enters SCAN and emits exactly one beat with idx_o=0, onehot_o=0, first_o=1, last_o=1, count_o=0, then returns to IDLE. Consumers detect an empty word by onehot_o==0.
- Undefined: an accepted zero word is consumed silently. The block stays in IDLE, emits no beat and keeps data_rdy_o=1 on the next cycle.

## Test plan
- DATA_W=8, data_i=0xA5, dir_i=0, idx_rdy_i=1 -> beats idx 0,2,5,7; onehot 0x01,0x04,0x20,0x80; first only on idx 0, last only on idx 7; count_o=4 on all beats; data_rdy_o=1 again one cycle after the last beat.
- data_i=0xA5, dir_i=1 -> beats idx 7,5,2,0 with first on 7 and last on 0. Toggling dir_i during SCAN has no effect.
- data_i=0x24, dir_i=0, idx_rdy_i low for 3 cycles on the first beat -> idx_o=2, onehot_o=0x04, first_o=1 held for 3 cycles, then idx 5 with last_o=1.
- data_i=0x80 -> a single beat with idx_o=7, first_o=1, last_o=1, count_o=1. data_i=0xFF -> 8 consecutive beats, count_o=8.
- data_i=0x00, run with and without BIT_SCAN_ZERO_BEAT_EN -> one beat (onehot_o=0, count_o=0, first/last=1) versus no beat with data_rdy_o staying 1.
- rst_n_i pulled low asynchronously after 2 of 4 beats of 0xF0 -> all outputs reach reset values without waiting for a clock edge. After release, no residual beats appear, and the next word 0x03 yields exactly idx 0,1.
